matvec_postproc: RTL and testbench

Post-processing stage directly downstream of `matvec_mult`. It consumes the stream of 32-bit signed row dot products, adds a per-row bias, rounds and saturates back to DATA_WIDTH fixed point, and applies an optional hard activation. Results are packed into BANDWIDTH-wide chunks whose write strobe and base address match the `vector_in` load port of the next `matvec_mult` pass, so LSTM gate outputs feed the following layer without software repacking.

---
 rtl/lstm_pkg.sv | 20 ++
 rtl/hard_act.sv | 79 +++++++
 rtl/matvec_postproc.sv | 208 ++++++++++++++++++++
 tb/tb_matvec_postproc.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lstm_pkg.sv
// Shared types and fixed-point constants for the LSTM post-processing path.
package lstm_pkg;

  localparam int LSTM_FRAC_BITS = 12;
  localparam int LSTM_ONE       = 32'sd1 <<< LSTM_FRAC_BITS;

  // Activation select encoding; code 3 is treated as no activation.
  typedef enum logic [1:0] {
    ACT_NONE    = 2'd0,
    ACT_SIGMOID = 2'd1,
    ACT_TANH    = 2'd2
  } act_t;

  // FSM state type and encodings.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_COLLECT = 2'd1;
  localparam state_t ST_DONE    = 2'd2;

endpackage

// File: rtl/hard_act.sv
// Stage-2 combinational datapath: round half up, saturate to DATA_WIDTH, apply hard activation.
module hard_act
  import lstm_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = LSTM_FRAC_BITS,
  parameter int ONE        = LSTM_ONE,
  parameter int SUM_W      = 33
) (
  input  logic signed [SUM_W-1:0]      i_sum,
  input  logic        [1:0]            i_act_sel,
  output logic        [DATA_WIDTH-1:0] o_y,
  output logic                         o_sat
);

  localparam int EXT_W = SUM_W + 1;       // headroom for the rounding add
  localparam int ACT_W = DATA_WIDTH + 2;  // headroom for sigmoid offset and clamps

  localparam logic signed [EXT_W-1:0] LSB_E    = {{(EXT_W-1){1'b0}}, 1'b1};
  localparam logic signed [EXT_W-1:0] HALF_LSB = LSB_E <<< (FRAC_BITS - 1);
  localparam logic signed [EXT_W-1:0] SAT_MAX  = (LSB_E <<< (DATA_WIDTH - 1)) - LSB_E;
  localparam logic signed [EXT_W-1:0] SAT_MIN  = -(LSB_E <<< (DATA_WIDTH - 1));

  localparam logic signed [ACT_W-1:0] ONE_A  = ACT_W'(ONE);
  localparam logic signed [ACT_W-1:0] HALF_A = ACT_W'(ONE / 2);
  localparam logic signed [ACT_W-1:0] ZERO_A = {ACT_W{1'b0}};

  logic signed [EXT_W-1:0]      w_rnd;
  logic signed [EXT_W-1:0]      w_r;
  logic signed [DATA_WIDTH-1:0] w_x;
  logic signed [ACT_W-1:0]      w_xa;
  logic signed [ACT_W-1:0]      w_sig;
  logic signed [ACT_W-1:0]      w_t;
  logic                         w_unused_t;

  // Round, saturate, then select the activation on the saturated value.
  always_comb begin
    w_rnd = $signed({i_sum[SUM_W-1], i_sum}) + HALF_LSB;
    w_r   = w_rnd >>> FRAC_BITS;
    if (w_r > SAT_MAX) begin
      w_x   = SAT_MAX[DATA_WIDTH-1:0];
      o_sat = 1'b1;
    end else if (w_r < SAT_MIN) begin
      w_x   = SAT_MIN[DATA_WIDTH-1:0];
      o_sat = 1'b1;
    end else begin
      w_x   = w_r[DATA_WIDTH-1:0];
      o_sat = 1'b0;
    end
    w_xa  = {{2{w_x[DATA_WIDTH-1]}}, w_x};
    w_sig = (w_xa >>> 2) + HALF_A;
    case (i_act_sel)
      ACT_SIGMOID: begin
        if (w_sig < ZERO_A) begin
          w_t = ZERO_A;
        end else if (w_sig > ONE_A) begin
          w_t = ONE_A;
        end else begin
          w_t = w_sig;
        end
      end
      ACT_TANH: begin
        if (w_xa < -ONE_A) begin
          w_t = -ONE_A;
        end else if (w_xa > ONE_A) begin
          w_t = ONE_A;
        end else begin
          w_t = w_xa;
        end
      end
      default: w_t = w_xa;
    endcase
    o_y = w_t[DATA_WIDTH-1:0];
  end

  // Guard bits of the clamped result always equal the sign bit.
  assign w_unused_t = ^w_t[ACT_W-1:DATA_WIDTH];

endmodule

// File: rtl/matvec_postproc.sv
// Bias-add, round/saturate, hard activation and chunk packing for matvec_mult row results.
module matvec_postproc
  import lstm_pkg::*;
#(
  parameter int MAX_ROWS   = 64,
  parameter int BANDWIDTH  = 16,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = LSTM_FRAC_BITS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [$clog2(MAX_ROWS):0]       num_rows,
  input  logic [1:0]                      act_sel,
  input  logic                            bias_we,
  input  logic [$clog2(MAX_ROWS)-1:0]     bias_addr,
  input  logic [DATA_WIDTH-1:0]           bias_data,
  input  logic [2*DATA_WIDTH-1:0]         result_in,
  input  logic                            result_valid_in,
  output logic [DATA_WIDTH*BANDWIDTH-1:0] vec_out,
  output logic                            vec_write_enable,
  output logic [$clog2(MAX_ROWS)-1:0]     vec_base_addr,
  output logic                            overflow,
  output logic                            done,
  output logic                            busy
);

  localparam int ADDR_W = $clog2(MAX_ROWS);
  localparam int ROW_W  = ADDR_W + 1;
  localparam int LANE_W = $clog2(BANDWIDTH);
  localparam int SUM_W  = 2 * DATA_WIDTH + 1;

  state_t                               r_state;
  state_t                               w_state_nxt;
  logic [ROW_W-1:0]                     r_num_rows;
  logic [1:0]                           r_act_sel;
  logic [DATA_WIDTH-1:0]                r_bias [MAX_ROWS];
  logic [ROW_W-1:0]                     r_row;
  logic                                 r_s1_valid;
  logic signed [SUM_W-1:0]              r_s1_sum;
  logic [ROW_W-1:0]                     r_s1_row;
  logic [BANDWIDTH-1:0][DATA_WIDTH-1:0] r_buf;
  logic [BANDWIDTH-1:0][DATA_WIDTH-1:0] w_chunk;
  logic [BANDWIDTH-1:0][DATA_WIDTH-1:0] r_vec_out;
  logic                                 r_vec_we;
  logic [ADDR_W-1:0]                    r_vec_base;
  logic                                 r_last;
  logic                                 r_overflow;
  logic                                 r_done;
  logic                                 r_busy;

  logic                                 w_start_pass;
  logic                                 w_accept;
  logic [DATA_WIDTH-1:0]                w_bias_row;
  logic [SUM_W-1:0]                     w_sum;
  logic [ROW_W-1:0]                     w_row_mod;
  logic [LANE_W-1:0]                    w_lane;
  logic                                 w_last_row;
  logic                                 w_emit;
  logic [DATA_WIDTH-1:0]                w_y;
  logic                                 w_sat;

  assign w_start_pass = (r_state == ST_IDLE) && start && (num_rows != {ROW_W{1'b0}});
  assign w_accept     = (r_state == ST_COLLECT) && result_valid_in && (r_row < r_num_rows);
  assign w_bias_row   = r_bias[r_row[ADDR_W-1:0]];
  assign w_sum        = {result_in[2*DATA_WIDTH-1], result_in}
                      + ({{(SUM_W-DATA_WIDTH){w_bias_row[DATA_WIDTH-1]}}, w_bias_row} << FRAC_BITS);
  assign w_row_mod    = r_s1_row % ROW_W'(BANDWIDTH);
  assign w_lane       = w_row_mod[LANE_W-1:0];
  assign w_last_row   = (r_s1_row == (r_num_rows - {{(ROW_W-1){1'b0}}, 1'b1}));
  assign w_emit       = r_s1_valid && ((w_lane == LANE_W'(BANDWIDTH - 1)) || w_last_row);

  hard_act #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS),
    .ONE        (32'sd1 <<< FRAC_BITS),
    .SUM_W      (SUM_W)
  ) u_hard_act (
    .i_sum     (r_s1_sum),
    .i_act_sel (r_act_sel),
    .o_y       (w_y),
    .o_sat     (w_sat)
  );

  // Bias memory: cleared by reset, writable only while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_ROWS; i++) begin
        r_bias[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (bias_we && (r_state == ST_IDLE)) begin
      r_bias[bias_addr] <= bias_data;
    end
  end

  // Latch pass configuration when a start is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_num_rows <= {ROW_W{1'b0}};
      r_act_sel  <= 2'd0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_num_rows <= num_rows;
      r_act_sel  <= act_sel;
    end
  end

  // Stage 1: bias add and row counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row      <= {ROW_W{1'b0}};
      r_s1_valid <= 1'b0;
      r_s1_sum   <= {SUM_W{1'b0}};
      r_s1_row   <= {ROW_W{1'b0}};
    end else begin
      r_s1_valid <= w_accept;
      if (w_start_pass) begin
        r_row <= {ROW_W{1'b0}};
      end else if (w_accept) begin
        r_s1_sum <= w_sum;
        r_s1_row <= r_row;
        r_row    <= r_row + {{(ROW_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Chunk image with the current stage-2 lane merged in.
  always_comb begin
    w_chunk         = r_buf;
    w_chunk[w_lane] = w_y;
  end

  // Stage 2: lane buffer fill, chunk emission and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf      <= {(BANDWIDTH*DATA_WIDTH){1'b0}};
      r_vec_out  <= {(BANDWIDTH*DATA_WIDTH){1'b0}};
      r_vec_we   <= 1'b0;
      r_vec_base <= {ADDR_W{1'b0}};
      r_last     <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_start_pass) begin
      r_buf      <= {(BANDWIDTH*DATA_WIDTH){1'b0}};
      r_vec_we   <= 1'b0;
      r_last     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_vec_we <= 1'b0;
      if (r_s1_valid) begin
        if (w_sat) begin
          r_overflow <= 1'b1;
        end
        if (w_emit) begin
          r_vec_out  <= w_chunk;
          r_vec_we   <= 1'b1;
          r_vec_base <= ADDR_W'(r_s1_row - w_row_mod);
          r_last     <= w_last_row;
          r_buf      <= {(BANDWIDTH*DATA_WIDTH){1'b0}};
        end else begin
          r_buf[w_lane] <= w_y;
        end
      end
    end
  end

  // Next-state logic: leave COLLECT once the final chunk has been strobed.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = (num_rows == {ROW_W{1'b0}}) ? ST_DONE : ST_COLLECT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (r_vec_we && r_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_COLLECT;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register with registered done/busy decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (w_state_nxt == ST_DONE);
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  assign vec_out          = r_vec_out;
  assign vec_write_enable = r_vec_we;
  assign vec_base_addr    = r_vec_base;
  assign overflow         = r_overflow;
  assign done             = r_done;
  assign busy             = r_busy;

endmodule

// File: tb/tb_matvec_postproc.sv
// Randomised self-checking bench for matvec_postproc against an arithmetic reference model.
module tb_matvec_postproc;

  localparam int MR = 64;
  localparam int BW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [6:0]    num_rows;
  logic [1:0]    act_sel;
  logic          bias_we;
  logic [5:0]    bias_addr;
  logic [15:0]   bias_data;
  logic [31:0]   result_in;
  logic          result_valid_in;
  logic [255:0]  vec_out;
  logic          vec_write_enable;
  logic [5:0]    vec_base_addr;
  logic          overflow;
  logic          done;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int bias_m [MR];

  int           st_cyc [$];
  int           st_base[$];
  logic [255:0] st_data[$];
  int           dn_cyc [$];

  matvec_postproc #(.MAX_ROWS(MR), .BANDWIDTH(BW), .DATA_WIDTH(DW), .FRAC_BITS(12)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .num_rows         (num_rows),
    .act_sel          (act_sel),
    .bias_we          (bias_we),
    .bias_addr        (bias_addr),
    .bias_data        (bias_data),
    .result_in        (result_in),
    .result_valid_in  (result_valid_in),
    .vec_out          (vec_out),
    .vec_write_enable (vec_write_enable),
    .vec_base_addr    (vec_base_addr),
    .overflow         (overflow),
    .done             (done),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe and done pulse with the cycle it was seen in.
  always @(negedge clk) begin
    if (vec_write_enable) begin
      st_cyc.push_back(cyc);
      st_base.push_back(int'(vec_base_addr));
      st_data.push_back(vec_out);
    end
    if (done) dn_cyc.push_back(cyc);
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: Q24 dot product plus Q12 bias, round half up, saturate, activate.
  function automatic logic [15:0] ref_row(input logic [31:0] res, input int b, input int act,
                                          output bit sat);
    longint s, r, x, t;
    logic [63:0] tv;
    s   = longint'($signed(res)) + longint'(b) * 64'sd4096;
    r   = (s + 64'sd2048) >>> 12;
    sat = 1'b0;
    x   = r;
    if (r > 64'sd32767) begin x = 64'sd32767; sat = 1'b1; end
    else if (r < -64'sd32768) begin x = -64'sd32768; sat = 1'b1; end
    case (act)
      1: begin
        t = (x >>> 2) + 64'sd2048;
        if (t < 64'sd0) t = 64'sd0;
        if (t > 64'sd4096) t = 64'sd4096;
      end
      2: begin
        t = x;
        if (t < -64'sd4096) t = -64'sd4096;
        if (t > 64'sd4096) t = 64'sd4096;
      end
      default: t = x;
    endcase
    tv = t;
    return tv[15:0];
  endfunction

  task automatic write_bias(input int a, input logic [15:0] d);
    bias_we = 1'b1; bias_addr = 6'(a); bias_data = d;
    tick();
    bias_we = 1'b0;
    bias_m[a] = int'($signed(d));
  endtask

  task automatic clear_mon();
    st_cyc.delete(); st_base.delete(); st_data.delete(); dn_cyc.delete();
  endtask

  task automatic run_pass(input string nm, input int n, input int act, input bit b2b,
                          input logic [31:0] res[$]);
    int drv[$];
    int sc;
    int e_base[$];
    int e_cyc[$];
    logic [255:0] e_data[$];
    logic [255:0] cur;
    bit sats, s;
    int done_exp;
    clear_mon();
    start = 1'b1; num_rows = 7'(n); act_sel = 2'(act); sc = cyc;
    tick();
    start = 1'b0; num_rows = 7'($urandom_range(0, 64));
    chk({nm, "_busy_start"}, 256'(busy), 256'(1));
    for (int i = 0; i < n; i++) begin
      if (!b2b) begin
        repeat ($urandom_range(0, 2)) begin
          result_valid_in = 1'b0; result_in = $urandom;
          tick();
        end
      end
      result_valid_in = 1'b1; result_in = res[i];
      // Bias writes and starts while collecting must be ignored.
      bias_we = 1'($urandom_range(0, 1)); bias_addr = 6'($urandom); bias_data = 16'($urandom);
      start = 1'($urandom_range(0, 1));
      drv.push_back(cyc);
      tick();
    end
    start = 1'b0; bias_we = 1'b0;
    result_valid_in = b2b; result_in = $urandom;
    repeat (2) tick();
    result_valid_in = 1'b0;
    for (int k = 0; k < 200 && dn_cyc.size() == 0; k++) tick();
    repeat (3) tick();

    cur = '0; sats = 1'b0;
    for (int i = 0; i < n; i++) begin
      cur[(i % BW) * DW +: DW] = ref_row(res[i], bias_m[i], act, s);
      sats |= s;
      if ((i % BW) == BW - 1 || i == n - 1) begin
        e_data.push_back(cur); e_base.push_back(i - (i % BW)); e_cyc.push_back(drv[i] + 2);
        cur = '0;
      end
    end
    chk({nm, "_nstrobe"}, 256'(st_cyc.size()), 256'(e_data.size()));
    for (int j = 0; j < e_data.size() && j < st_cyc.size(); j++) begin
      chk($sformatf("%s_data%0d", nm, j), st_data[j], e_data[j]);
      chk($sformatf("%s_base%0d", nm, j), 256'(st_base[j]), 256'(e_base[j]));
      chk($sformatf("%s_lat%0d", nm, j), 256'(st_cyc[j]), 256'(e_cyc[j]));
    end
    done_exp = (n == 0) ? sc + 1 : drv[n-1] + 3;
    chk({nm, "_ndone"}, 256'(dn_cyc.size()), 256'(1));
    if (dn_cyc.size() > 0) chk({nm, "_done_cyc"}, 256'(dn_cyc[0]), 256'(done_exp));
    if (n > 0) begin
      chk({nm, "_overflow"}, 256'(overflow), 256'(sats));
      chk({nm, "_hold"}, vec_out, e_data[e_data.size()-1]);
    end
    chk({nm, "_busy_end"}, 256'(busy), 256'(0));
  endtask

  initial begin
    logic [31:0] q[$];
    logic signed [31:0] tmp;
    int n, act;
    rst = 1'b1; start = 1'b0; num_rows = '0; act_sel = '0; bias_we = 1'b0;
    bias_addr = '0; bias_data = '0; result_in = '0; result_valid_in = 1'b0;
    for (int i = 0; i < MR; i++) bias_m[i] = 0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_vec_out", vec_out, '0);
    chk("rst_we", 256'(vec_write_enable), '0);
    chk("rst_base", 256'(vec_base_addr), '0);
    chk("rst_ovf", 256'(overflow), '0);
    chk("rst_done", 256'(done), '0);
    chk("rst_busy", 256'(busy), '0);

    q = '{32'h0100_0000, 32'hFF00_0000, 32'h0000_0800, 32'h7FFF_FFFF};
    run_pass("none", 4, 0, 1'b1, q);
    chk("none_lanes", vec_out, {192'h0, 64'h7FFF_0001_F000_1000});
    chk("none_ovf_set", 256'(overflow), 256'(1));

    write_bias(0, 16'h0800);
    q = '{32'h0080_0000};
    run_pass("bias", 1, 0, 1'b1, q);
    chk("bias_lane0", vec_out, {240'h0, 16'h1000});

    write_bias(0, 16'h0000);
    q = '{32'h0000_0000, 32'h0100_0000, 32'h0400_0000, 32'hFC00_0000};
    run_pass("sig", 4, 1, 1'b0, q);
    chk("sig_lanes", vec_out, {192'h0, 64'h0000_1000_0C00_0800});

    q = '{32'h0200_0000, 32'hFFC0_0000};
    run_pass("tanh", 2, 2, 1'b1, q);
    chk("tanh_lanes", vec_out, {224'h0, 32'hFC00_1000});

    q = '{};
    for (int i = 0; i < 20; i++) begin tmp = $urandom; q.push_back(tmp >>> 10); end
    run_pass("rows20", 20, 0, 1'b1, q);

    for (int p = 0; p < 6; p++) begin
      n   = $urandom_range(1, MR);
      act = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) if ($urandom_range(0, 1)) write_bias(i, 16'($urandom));
      q = '{};
      for (int i = 0; i < n; i++) begin
        tmp = $urandom;
        q.push_back(tmp >>> $urandom_range(0, 16));
      end
      run_pass($sformatf("rnd%0d", p), n, act, 1'($urandom_range(0, 1)), q);
    end

    // Reset in the middle of a 20-row pass with saturating rows in flight.
    for (int i = 0; i < 3; i++) write_bias(i, 16'h1234);
    clear_mon();
    start = 1'b1; num_rows = 7'd20; act_sel = 2'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      result_valid_in = 1'b1; result_in = 32'h7FFF_FFFF;
      tick();
    end
    result_valid_in = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < MR; i++) bias_m[i] = 0;
    chk("mrst_busy", 256'(busy), '0);
    chk("mrst_ovf", 256'(overflow), '0);
    chk("mrst_vec_out", vec_out, '0);
    result_valid_in = 1'b1;
    repeat (4) begin result_in = $urandom; tick(); end
    result_valid_in = 1'b0;
    repeat (2) tick();
    chk("mrst_nstrobe", 256'(st_cyc.size()), '0);
    chk("mrst_ndone", 256'(dn_cyc.size()), '0);

    q = '{};
    run_pass("zero", 0, 0, 1'b1, q);

    q = '{32'h0000_1000, 32'h0010_0000, 32'hFFF0_0000};
    run_pass("bias_clr", 3, 0, 1'b1, q);
    chk("bias_clr_lanes", vec_out, {208'h0, 48'hFF00_0100_0001});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
